// File: rtl/load_store_unit_if.sv
// Bus bundle for load_store_unit: core request/response channel plus the
// word-addressed data-memory port.
//   master : the load/store unit (accepts requests, drives memory strobes)
//   slave  : the environment side (requesting core and the data memory)
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic        mem_read_enable;
   logic [31:0] mem_read_data;

   modport master (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_address, mem_write_data, mem_write_enable, mem_read_enable
   );

   modport slave (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_address, mem_write_data, mem_write_enable, mem_read_enable
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: converts byte-addressed RISC-V loads/stores into word
// accesses, extends load data, and does read-modify-write for SB/SH.
// Ports: clk, rst (async active-high), bus (load_store_unit_if.master).
// Latency: error 1 edge, SW 2 edges, loads and SB/SH 3 edges to resp_valid;
// req_ready is high only in IDLE, so requests stall while an access is in flight.
module load_store_unit #(
   parameter int MEM_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   load_store_unit_if.master bus
);
   typedef enum logic [2:0] {IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_WR} state_t;

   state_t      state_q, state_d;
   logic        store_q, store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic        accept;
   logic        req_err;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign accept = bus.req_valid && (state_q == IDLE);

   // Request validation on the live request inputs, used at acceptance.
   always_comb begin
      case (bus.req_funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_err = 1'b0;
         default:                                req_err = 1'b1;
      endcase
      if (bus.req_store && bus.req_funct3[2])
         req_err = 1'b1;
      if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
         req_err = 1'b1;
      if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00))
         req_err = 1'b1;
      if ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS))
         req_err = 1'b1;
   end

   // Load lane selection and extension from the returned memory word.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    ld_byte = bus.mem_read_data[7:0];
         2'd1:    ld_byte = bus.mem_read_data[15:8];
         2'd2:    ld_byte = bus.mem_read_data[23:16];
         default: ld_byte = bus.mem_read_data[31:24];
      endcase
      ld_half = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
      case (funct3_q)
         3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  load_ext = {24'h0, ld_byte};
         3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  load_ext = {16'h0, ld_half};
         default: load_ext = bus.mem_read_data;
      endcase
   end

   // Sub-word store merge: replace only the targeted lane of the old word.
   always_comb begin
      merged = bus.mem_read_data;
      if (!funct3_q[0]) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      store_d      = store_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               store_d  = bus.req_store;
               funct3_d = bus.req_funct3;
               addr_d   = bus.req_addr;
               wdata_d  = bus.req_wdata;
               if (req_err) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
               end else if (!bus.req_store) begin
                  state_d = LD_RD;
               end else if (bus.req_funct3 == 3'b010) begin
                  state_d = ST_WR;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         LD_RD:  state_d = LD_CAP;
         LD_CAP: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = load_ext;
         end
         RMW_RD: state_d = RMW_WR;
         ST_WR, RMW_WR: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'h0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         store_q      <= 1'b0;
         funct3_q     <= 3'b000;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         store_q      <= store_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign bus.req_ready        = (state_q == IDLE);
   assign bus.resp_valid       = resp_valid_q;
   assign bus.resp_err         = resp_err_q;
   assign bus.resp_rdata       = resp_rdata_q;
   assign bus.mem_address      = {2'b00, addr_q[31:2]};
   assign bus.mem_write_data   = (state_q == RMW_WR) ? merged : wdata_q;
   assign bus.mem_read_enable  = (state_q == LD_RD) || (state_q == RMW_RD);
   assign bus.mem_write_enable = (state_q == ST_WR) || (state_q == RMW_WR);

   // store_q is kept with the latched request for visibility; not needed for decode.
   logic unused_store;
   assign unused_store = store_q;
endmodule
